// File: rtl/keyboard_input_controller.sv
// rtl/keyboard_input_controller.sv - keyboard byte FIFO with interrupt delivery and memory-mapped pop port
module keyboard_input_controller #(
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int          IRQ_GAP      = 4,
    parameter logic        IRQ_EN_RESET = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_strobe,
    input  logic [7:0]                    rx_byte,
    output logic                          keyboard_interrupt,
    output logic [7:0]                    keycode,
    input  logic [31:0]                   mem_addr,
    input  logic [31:0]                   mem_data_i,
    input  logic [3:0]                    mem_data_en,
    input  logic                          mem_read_en,
    input  logic                          mem_write_en,
    output logic [31:0]                   mem_data_o,
    output logic                          mem_hit,
    output logic                          mem_done,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = $clog2(IRQ_GAP + 1);

    typedef enum logic [1:0] {M_IDLE, M_DONE, M_WAIT} m_state_e;
    typedef enum logic [1:0] {I_IDLE, I_FIRE, I_GAP} i_state_e;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          irq_en_q, irq_en_d;

    m_state_e      m_state_q;
    logic [31:0]   mem_data_q;
    logic          mem_done_q;

    i_state_e      i_state_q;
    logic [GW-1:0] gap_q;
    logic [7:0]    keycode_q;
    logic          kbd_irq_q;

    logic [31:0] addr_off;
    logic        empty, full;
    logic        mem_req, mem_rd, mem_wr, data_sel;
    logic        mem_pop, irq_pop, pop, push, drop, status_wr;
    logic [7:0]  head;
    logic [31:0] status_word, data_word;
    logic        unused_ok;

    assign addr_off = mem_addr - BASE_ADDR;
    assign mem_hit  = (mem_addr >= BASE_ADDR) && (addr_off < 32'd8);
    assign data_sel = mem_addr[2];

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign head  = fifo_mem[rd_ptr_q];

    assign mem_req   = (m_state_q == M_IDLE) && mem_hit && (mem_read_en || mem_write_en);
    assign mem_rd    = mem_req && mem_read_en;
    assign mem_wr    = mem_req && !mem_read_en;
    assign status_wr = mem_wr && !data_sel && mem_data_en[1];

    // Memory pop wins; the interrupt simply waits for its next opportunity.
    assign mem_pop = mem_rd && data_sel && !empty;
    assign irq_pop = (i_state_q == I_IDLE) && irq_en_q && !empty && !mem_pop;
    assign pop     = mem_pop || irq_pop;
    assign push    = rx_strobe && (!full || pop);
    assign drop    = rx_strobe && !push;

    assign status_word = {21'b0, irq_en_q, overflow_q, empty, 3'b0, 5'(count_q)};
    assign data_word   = empty ? 32'h0 : {23'b0, 1'b1, head};

    assign unused_ok = ^{mem_data_i[31:11], mem_data_i[8:0], mem_data_en[3:2], mem_data_en[0]};

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
        overflow_d = overflow_q;
        irq_en_d   = irq_en_q;
        if (status_wr) begin
            irq_en_d = mem_data_i[10];
            if (mem_data_i[9]) begin
                overflow_d = 1'b0;
            end
        end
        // A drop at the same edge as a clear still leaves overflow set.
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= rx_byte;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            irq_en_q   <= IRQ_EN_RESET;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            irq_en_q   <= irq_en_d;
        end
    end

    // M_WAIT blocks a held request from being serviced twice.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_state_q  <= M_IDLE;
            mem_data_q <= '0;
            mem_done_q <= 1'b0;
        end else begin
            case (m_state_q)
                M_IDLE: begin
                    mem_done_q <= 1'b0;
                    if (mem_req) begin
                        mem_done_q <= 1'b1;
                        m_state_q  <= M_DONE;
                        if (mem_rd) begin
                            mem_data_q <= data_sel ? data_word : status_word;
                        end else begin
                            mem_data_q <= '0;
                        end
                    end
                end
                M_DONE: begin
                    mem_done_q <= 1'b0;
                    m_state_q  <= M_WAIT;
                end
                M_WAIT: begin
                    mem_done_q <= 1'b0;
                    if (!mem_read_en && !mem_write_en) begin
                        m_state_q <= M_IDLE;
                    end
                end
                default: begin
                    mem_done_q <= 1'b0;
                    m_state_q  <= M_IDLE;
                end
            endcase
        end
    end

    // The gap counter leaves exactly IRQ_GAP low cycles after each pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_state_q <= I_IDLE;
            gap_q     <= '0;
            keycode_q <= '0;
            kbd_irq_q <= 1'b0;
        end else begin
            case (i_state_q)
                I_IDLE: begin
                    kbd_irq_q <= 1'b0;
                    if (irq_pop) begin
                        keycode_q <= head;
                        kbd_irq_q <= 1'b1;
                        i_state_q <= I_FIRE;
                    end
                end
                I_FIRE: begin
                    kbd_irq_q <= 1'b0;
                    gap_q     <= GW'(IRQ_GAP - 1);
                    i_state_q <= (IRQ_GAP == 1) ? I_IDLE : I_GAP;
                end
                I_GAP: begin
                    kbd_irq_q <= 1'b0;
                    gap_q     <= gap_q - 1'b1;
                    if (gap_q <= GW'(1)) begin
                        i_state_q <= I_IDLE;
                    end
                end
                default: begin
                    kbd_irq_q <= 1'b0;
                    i_state_q <= I_IDLE;
                end
            endcase
        end
    end

    assign keyboard_interrupt = kbd_irq_q;
    assign keycode            = keycode_q;
    assign mem_data_o         = mem_data_q;
    assign mem_done           = mem_done_q;
    assign count              = count_q;

endmodule

// File: tb/tb_keyboard_input_controller.sv
// tb/tb_keyboard_input_controller.sv - directed self-checking bench for keyboard_input_controller
module tb_keyboard_input_controller;

    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [31:0] STATUS = BASE;
    localparam logic [31:0] DATA   = BASE + 32'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_strobe;
    logic [7:0]  rx_byte;
    logic        keyboard_interrupt;
    logic [7:0]  keycode;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_i;
    logic [3:0]  mem_data_en;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_data_o;
    logic        mem_hit;
    logic        mem_done;
    logic [4:0]  count;

    int chk_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int wide_cnt = 0;
    logic irq_prev = 1'b0;
    logic [7:0] pq_code[$];
    int         pq_cyc[$];

    keyboard_input_controller #(
        .FIFO_DEPTH(16), .BASE_ADDR(BASE), .IRQ_GAP(4), .IRQ_EN_RESET(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .rx_strobe(rx_strobe), .rx_byte(rx_byte),
        .keyboard_interrupt(keyboard_interrupt), .keycode(keycode),
        .mem_addr(mem_addr), .mem_data_i(mem_data_i), .mem_data_en(mem_data_en),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_data_o(mem_data_o), .mem_hit(mem_hit), .mem_done(mem_done), .count(count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (keyboard_interrupt) begin
            pq_code.push_back(keycode);
            pq_cyc.push_back(cyc);
            if (irq_prev) wide_cnt++;
        end
        irq_prev = keyboard_interrupt;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic strobe(input logic [7:0] b);
        rx_strobe = 1'b1;
        rx_byte   = b;
        @(negedge clk);
        rx_strobe = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        bit got = 0;
        data = 32'hDEAD_BEEF;
        mem_addr    = addr;
        mem_read_en = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (mem_done) begin
                got  = 1;
                data = mem_data_o;
            end
        end
        if (!got) check("read_timeout", 32'd0, 32'd1);
        mem_read_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] en);
        bit got = 0;
        mem_addr     = addr;
        mem_data_i   = wd;
        mem_data_en  = en;
        mem_write_en = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (mem_done) got = 1;
        end
        check("write_done", 32'(got), 32'd1);
        mem_write_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        int c0, dn;

        reset = 1'b0; rx_strobe = 1'b0; rx_byte = '0;
        mem_addr = '0; mem_data_i = '0; mem_data_en = '0;
        mem_read_en = 1'b0; mem_write_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_irq", 32'(keyboard_interrupt), 32'd0);
        check("rst_done", 32'(mem_done), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_keycode", 32'(keycode), 32'd0);
        check("rst_data_o", mem_data_o, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        mem_addr = BASE - 32'd1; #1 check("hit_below", 32'(mem_hit), 32'd0);
        mem_addr = BASE + 32'd7; #1 check("hit_top", 32'(mem_hit), 32'd1);
        mem_addr = BASE + 32'd8; #1 check("hit_above", 32'(mem_hit), 32'd0);
        @(negedge clk);

        // single byte: pulse two edges after the strobe edge
        c0 = cyc;
        strobe(8'h1C);
        repeat (8) @(negedge clk);
        check("single_npulse", 32'(pq_code.size()), 32'd1);
        if (pq_code.size() >= 1) begin
            check("single_code", 32'(pq_code[0]), 32'h1C);
            check("single_lat", 32'(pq_cyc[0]), 32'(c0 + 2));
        end
        check("single_count", 32'(count), 32'd0);
        bus_read(STATUS, rd);
        check("single_status", rd, 32'h0000_0500);

        // burst with gap
        pq_code.delete(); pq_cyc.delete();
        c0 = cyc;
        strobe(8'h10); strobe(8'h11); strobe(8'h12);
        repeat (20) @(negedge clk);
        check("burst_npulse", 32'(pq_code.size()), 32'd3);
        for (int i = 0; i < 3 && i < pq_code.size(); i++) begin
            check($sformatf("burst_code%0d", i), 32'(pq_code[i]), 32'(8'h10 + i));
            check($sformatf("burst_cyc%0d", i), 32'(pq_cyc[i]), 32'(c0 + 2 + 5 * i));
        end
        check("pulse_width", 32'(wide_cnt), 32'd0);

        // overflow with interrupts disabled
        bus_write(STATUS, 32'h0, 4'b0010);
        for (int i = 0; i < 17; i++) strobe(8'(i));
        @(negedge clk);
        check("ovf_count", 32'(count), 32'd16);
        bus_read(STATUS, rd);
        check("ovf_status", rd, 32'h0000_0210);
        for (int i = 0; i < 16; i++) begin
            bus_read(DATA, rd);
            check($sformatf("ovf_rd%0d", i), rd, 32'h100 + i);
        end
        bus_read(DATA, rd);
        check("ovf_rd_empty", rd, 32'h0);
        bus_read(STATUS, rd);
        check("ovf_status_empty", rd, 32'h0000_0300);
        bus_write(STATUS, 32'h0000_0200, 4'b0010);
        bus_read(STATUS, rd);
        check("ovf_cleared", rd, 32'h0000_0100);

        // full FIFO with push and pop at the same edge
        for (int i = 0; i < 16; i++) strobe(8'h20 + 8'(i));
        mem_addr = DATA; mem_read_en = 1'b1;
        rx_strobe = 1'b1; rx_byte = 8'hAA;
        @(negedge clk);
        rx_strobe = 1'b0;
        check("fullpop_done", 32'(mem_done), 32'd1);
        check("fullpop_data", mem_data_o, 32'h120);
        mem_read_en = 1'b0;
        repeat (2) @(negedge clk);
        check("fullpop_count", 32'(count), 32'd16);
        bus_read(STATUS, rd);
        check("fullpop_status", rd, 32'h0000_0010);
        for (int i = 1; i < 16; i++) begin
            bus_read(DATA, rd);
            check($sformatf("fullpop_rd%0d", i), rd, 32'h120 + i);
        end
        bus_read(DATA, rd);
        check("fullpop_last", rd, 32'h1AA);

        // held read request pops only once
        strobe(8'h31); strobe(8'h32);
        check("held_pre_count", 32'(count), 32'd2);
        mem_addr = DATA; mem_read_en = 1'b1; dn = 0; rd = 32'h0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_done) begin dn++; rd = mem_data_o; end
        end
        mem_read_en = 1'b0;
        repeat (2) @(negedge clk);
        check("held_ndone", 32'(dn), 32'd1);
        check("held_data", rd, 32'h131);
        check("held_count", 32'(count), 32'd1);
        bus_read(DATA, rd);
        check("held_next", rd, 32'h132);

        // memory pop beats an interrupt fire opportunity
        bus_write(STATUS, 32'h0000_0400, 4'b0010);
        pq_code.delete(); pq_cyc.delete();
        rx_strobe = 1'b1; rx_byte = 8'h41;
        @(negedge clk);
        rx_byte = 8'h42; mem_addr = DATA; mem_read_en = 1'b1;
        @(negedge clk);
        rx_strobe = 1'b0;
        check("prio_done", 32'(mem_done), 32'd1);
        check("prio_data", mem_data_o, 32'h141);
        mem_read_en = 1'b0;
        repeat (10) @(negedge clk);
        check("prio_npulse", 32'(pq_code.size()), 32'd1);
        if (pq_code.size() >= 1) check("prio_code", 32'(pq_code[0]), 32'h42);

        // write-1-to-clear and ignored byte enables
        bus_write(STATUS, 32'h0, 4'b0010);
        for (int i = 0; i < 17; i++) strobe(8'h50 + 8'(i));
        bus_read(STATUS, rd);
        check("w1c_pre", rd, 32'h0000_0210);
        bus_write(STATUS, 32'h0000_0600, 4'b1101);
        bus_read(STATUS, rd);
        check("w1c_ignored_en", rd, 32'h0000_0210);
        bus_write(DATA, 32'hFFFF_FFFF, 4'b1111);
        check("data_write_count", 32'(count), 32'd16);
        bus_write(STATUS, 32'h0000_0200, 4'b0010);
        bus_read(STATUS, rd);
        check("w1c_status", rd, 32'h0000_0010);
        pq_code.delete(); pq_cyc.delete();
        repeat (30) @(negedge clk);
        check("w1c_no_pulse", 32'(pq_code.size()), 32'd0);
        check("w1c_count", 32'(count), 32'd16);

        // reset mid-operation empties the FIFO
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst2_count", 32'(count), 32'd0);
        bus_read(STATUS, rd);
        check("rst2_status", rd, 32'h0000_0500);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/keyboard_input_controller.md
# keyboard_input_controller

Producer end of the keyboard interrupt path into core0. It buffers raw bytes arriving from the keyboard front end in a FIFO and delivers them one at a time. Delivery is either a one-cycle `keyboard_interrupt` pulse with `keycode`, or a memory-mapped pop through a 32-bit `mem_if`-style responder port. It sits between the board keyboard interface and core0's `keyboard_interrupt`/`keycode` inputs, and hangs off a 4-byte memory server.

## Interface
- `FIFO_DEPTH`, 16: entries. Power of two, at least 2.
- `BASE_ADDR`, 32'h3000_0000: base of the 8-byte register window.
- `IRQ_GAP`, 4: idle cycles between consecutive interrupt pulses. At least 1.
- `IRQ_EN_RESET`, 1: reset value of `irq_enable`.
- `clk` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-low reset. Asserted when 0.
- `rx_strobe` in 1: one new byte on `rx_byte` this cycle. There is no backpressure.
- `rx_byte` in 8: incoming scancode.
- `keyboard_interrupt` out 1: one-cycle delivery pulse to core0.
- `keycode` out 8: byte delivered by the most recent pulse. It holds its value between pulses.
- `mem_addr` in 32: request address.
- `mem_data_i` in 32: write data.
- `mem_data_en` in 4: byte enables. Only byte 1 of STATUS is honoured.
- `mem_read_en` in 1: read request. Held until `mem_done`.
- `mem_write_en` in 1: write request. Held until `mem_done`.
- `mem_data_o` out 32: read data. Valid only while `mem_done` is 1.
- `mem_hit` out 1: combinational. It is 1 when `BASE_ADDR <= mem_addr < BASE_ADDR+8`.
- `mem_done` out 1: one-cycle completion pulse.
- `count` out log2(FIFO_DEPTH)+1: current occupancy, for debug.

## Operation
- FIFO: circular buffer with read and write pointers of width log2(FIFO_DEPTH). Both pointers wrap modulo FIFO_DEPTH.
  - `count` runs from 0 to FIFO_DEPTH.
- Push: `rx_strobe` is 1 at an edge.
  - The byte is accepted if the pre-edge count is below FIFO_DEPTH.
  - It is also accepted if the FIFO is full and a pop occurs at the same edge. Count is then unchanged.
  - Otherwise the byte is dropped and sticky `overflow` is set.
- Pop sources are the memory DATA read and the interrupt FSM. At most one pop happens per edge, and the memory pop has priority.
- Register map, at offset from `BASE_ADDR`:
  - 0x0 STATUS, read: `{21'b0, irq_enable[10], overflow[9], empty[8], 3'b0, count[4:0]}`. `count` is zero-extended and truncated to 5 bits.
  - 0x0 STATUS, write with `mem_data_en[1]`=1: `irq_enable` is loaded from `data_i[10]`. If `data_i[9]`=1, `overflow` is cleared (write-1-to-clear). Other enables are ignored.
  - 0x4 DATA, read: returns `{23'b0, valid[8], byte[7:0]}`.
    - When the FIFO is non-empty, `valid` is 1, `byte` is the head entry, and the head is popped.
    - When the FIFO is empty, 0x0 is returned.
  - 0x4 DATA, write: no effect. `mem_done` still pulses.
  - Any hit offset is decoded on `mem_addr[2]`. Requests that miss are ignored and never get `mem_done`.
- Memory FSM:
  - M_IDLE, on a hit with (`read_en` or `write_en`): perform the access at this edge, then go to M_DONE. `read_en` has priority if both are high.
  - M_DONE: `mem_done`=1 with `mem_data_o` registered. Always go to M_WAIT.
  - M_WAIT: stay until `read_en` and `write_en` are both 0, then go to M_IDLE. This prevents a held request from popping twice.
- Interrupt FSM:
  - I_IDLE: go to I_FIRE when `irq_enable` is 1, the FIFO is non-empty, and there is no memory pop at this edge. The head is popped into `keycode` at this edge.
  - I_FIRE: `keyboard_interrupt`=1. Go to I_GAP with the gap counter set to IRQ_GAP-1.
  - I_GAP: decrement the counter each cycle. Go to I_IDLE when it reaches 0.
  - Clearing `irq_enable` never aborts a pulse in progress or a gap in progress.
- Reset values:
  - Pointers, `count`, `overflow`, `keycode`, `mem_data_o`: 0.
  - `keyboard_interrupt`, `mem_done`: 0.
  - `irq_enable`: IRQ_EN_RESET.
  - FSMs: I_IDLE and M_IDLE.
- Reset mid-operation discards FIFO contents and any in-flight response. No `mem_done` is produced for an aborted request.

## Timing
- Byte strobe sampled at edge E0 to `keyboard_interrupt` high: the cycle after E1, so 2 edges. This holds with the FIFO empty, the FSM in I_IDLE, and enable set.
- Pulse width is exactly 1 cycle. The minimum spacing between pulse starts is IRQ_GAP+1 cycles.
- Memory latency: a request sampled at edge K gives `mem_done` in the cycle after K. The next request can be accepted no earlier than 2 edges after the request drops.
- `mem_hit` is combinational from `mem_addr`. Every other output is registered.

## Test plan
- Reset then a single byte: `reset`=0 for 3 cycles, then release and strobe 0x1C. Expect `keyboard_interrupt` high for exactly 1 cycle, 2 edges later, with `keycode`=0x1C. After that, `count`=0 and STATUS reads 0x0000_0500.
- Burst with gap: strobe 0x10, 0x11, 0x12 on consecutive cycles with IRQ_GAP=4. Expect 3 pulses exactly 5 cycles apart, with `keycode` values in order.
- Overflow: `irq_enable`=0, then 17 strobes of 0x00 through 0x10 with FIFO_DEPTH=16. Expect STATUS `count`=16 and `overflow`=1. 16 DATA reads return 0x100 through 0x10F. The 17th read returns 0x0.
- Full plus simultaneous pop: the FIFO is full, and a DATA read is accepted at the same edge as `rx_strobe` 0xAA. Expect `count` to stay at 16, `overflow` to stay 0, and 0xAA to be the last byte read out.
- Held request and priority:
  - Hold `read_en` on DATA for 6 cycles with 2 bytes queued. Expect one `mem_done` and one pop; `count` goes from 2 to 1.
  - A DATA read at the same edge as an interrupt fire opportunity wins. The interrupt delivers the next byte instead.
- Write-1-to-clear: with `overflow`=1, write STATUS 0x0000_0200 with `data_en`=4'b0010. Expect `overflow`=0 and `irq_enable`=0 (`data_i[10]`=0), and no interrupt pulses afterwards.
